flt_addsub: RTL and testbench

FLT_ADDSUB -- requirements
Module: flt_addsub

---
 rtl/flt_pkg.sv | 28 ++
 rtl/flt_norm.sv | 53 +++++
 rtl/flt_addsub.sv | 196 +++++++++++++++++++
 tb/tb_flt_addsub.sv | 120 ++++++++++++
 4 files changed

// File: rtl/flt_pkg.sv
// -----------------------------------------------------------------------------
// flt_pkg
// Shared definitions for the multi-cycle floating-point adder/subtractor:
//   - state_t      : controller state encoding
//   - EXP_W_DEF    : default exponent field width
//   - MAN_W_DEF    : default stored fraction width (hidden bit excluded)
//   - exp_bias()   : IEEE-style exponent bias for a given exponent width
// -----------------------------------------------------------------------------
package flt_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_PACK   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/flt_norm.sv
// -----------------------------------------------------------------------------
// flt_norm
// One normalisation step for the working mantissa
// {carry, hidden, fraction, guard, round, sticky}.
//   mant, exp      : current working mantissa / exponent
//   need           : the current value still needs a normalisation step
//   mant_step,
//   exp_step       : value after one step (unchanged when need=0)
//   need_step      : the stepped value still needs another step
// A carry is resolved with a single right shift (sticky preserved); otherwise
// the value is shifted left one bit until the hidden bit is set or the
// exponent reaches 1 (subnormal).
// -----------------------------------------------------------------------------
module flt_norm
    import flt_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [MAN_W+4:0] mant,
    input  logic [EXP_W:0]   exp,
    output logic             need,
    output logic [MAN_W+4:0] mant_step,
    output logic [EXP_W:0]   exp_step,
    output logic             need_step
);

    localparam int MW = MAN_W + 5;
    localparam logic [EXP_W:0] ONE = (EXP_W+1)'(1);

    logic carry;
    logic can_left;

    assign carry    = mant[MW-1];
    assign can_left = !mant[MW-2] && (exp > ONE) && (mant != '0);
    assign need     = carry || can_left;

    always_comb begin
        mant_step = mant;
        exp_step  = exp;
        need_step = 1'b0;
        if (carry) begin
            // Bits 1 and 0 both fall into the sticky position.
            mant_step = {1'b0, mant[MW-1:2], mant[1] | mant[0]};
            exp_step  = exp + ONE;
        end else if (can_left) begin
            mant_step = {mant[MW-2:0], 1'b0};
            exp_step  = exp - ONE;
            need_step = !mant[MW-3] && ((exp - ONE) > ONE);
        end
    end

endmodule

// File: rtl/flt_addsub.sv
// -----------------------------------------------------------------------------
// flt_addsub
// Multi-cycle floating-point adder/subtractor (sign, biased exponent, fraction).
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   start  : request pulse, operands and sub sampled on the same edge
//   op_a   : operand A
//   op_b   : operand B
//   sub    : 1 computes A-B, 0 computes A+B
//   result : packed result, valid while ack=1
//   ack    : done flag, held until the next accepted start or reset
// Latency from start edge to ack: 4 + alignment shifts + normalise shifts.
// Build option: define FLT_ROUND_EN for round-to-nearest-even in a two-cycle
// PACK; otherwise PACK truncates in one cycle.
// -----------------------------------------------------------------------------
module flt_addsub
    import flt_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ack
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 5;   // carry, hidden, fraction, G, R, S
    localparam logic [EXP_W:0] ONE   = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] CAP   = (EXP_W+1)'(MAN_W + 3);
    localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

    state_t            state;
    logic [W-1:0]      a_reg, b_reg;
    logic              sub_reg;
    logic              sign_big, sign_small;
    logic [EXP_W:0]    exp_reg;
    logic [EXP_W:0]    cnt;
    logic [MW-1:0]     mant_big, mant_small;

    // ---------------- unpack / swap (from captured operands) ----------------
    logic              swap, sign_b_eff;
    logic [W-1:0]      big_op, small_op;
    logic [EXP_W-1:0]  big_ef, small_ef;
    logic [EXP_W:0]    big_e, small_e, diff;

    assign sign_b_eff = b_reg[W-1] ^ sub_reg;
    // Exponent-then-fraction ordering equals magnitude ordering, even with
    // exponent 0 read as 1.
    assign swap     = b_reg[W-2:0] > a_reg[W-2:0];
    assign big_op   = swap ? b_reg : a_reg;
    assign small_op = swap ? a_reg : b_reg;
    assign big_ef   = big_op[W-2:MAN_W];
    assign small_ef = small_op[W-2:MAN_W];
    assign big_e    = (big_ef == '0)   ? ONE : {1'b0, big_ef};
    assign small_e  = (small_ef == '0) ? ONE : {1'b0, small_ef};
    assign diff     = big_e - small_e;

    // ---------------- add / subtract ----------------
    logic [MW-1:0] sum;
    assign sum = (sign_big == sign_small) ? (mant_big + mant_small)
                                          : (mant_big - mant_small);

    // ---------------- normaliser step ----------------
    logic [MW-1:0]  norm_in, mant_step;
    logic [EXP_W:0] exp_step;
    logic           norm_need, need_step;

    assign norm_in = (state == ST_ADD) ? sum : mant_big;

    flt_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
        .mant      (norm_in),
        .exp       (exp_reg),
        .need      (norm_need),
        .mant_step (mant_step),
        .exp_step  (exp_step),
        .need_step (need_step)
    );

    // ---------------- final packing ----------------
    logic [W-1:0] packed_val;
    always_comb begin
        if (exp_reg >= E_MAX) begin
            packed_val = {sign_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            // Hidden bit clear means subnormal (or zero): stored exponent 0.
            packed_val = {sign_big,
                          mant_big[MW-2] ? exp_reg[EXP_W-1:0] : {EXP_W{1'b0}},
                          mant_big[MW-3:3]};
        end
    end

`ifdef FLT_ROUND_EN
    logic              pack_phase;
    logic              rnd_inc;
    logic [MAN_W+1:0]  rnd;
    // Nearest-even: round up on guard when round/sticky set or LSB odd.
    assign rnd_inc = mant_big[2] & (mant_big[1] | mant_big[0] | mant_big[3]);
    assign rnd     = mant_big[MW-1:3] + (MAN_W+2)'(rnd_inc);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sub_reg    <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_reg    <= '0;
            cnt        <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            result     <= '0;
            ack        <= 1'b0;
`ifdef FLT_ROUND_EN
            pack_phase <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        ack     <= 1'b0;
                        state   <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sign_big   <= swap ? sign_b_eff : a_reg[W-1];
                    sign_small <= swap ? a_reg[W-1] : sign_b_eff;
                    exp_reg    <= big_e;
                    mant_big   <= {1'b0, |big_ef,   big_op[MAN_W-1:0],   3'b000};
                    mant_small <= {1'b0, |small_ef, small_op[MAN_W-1:0], 3'b000};
                    cnt        <= (diff > CAP) ? CAP : diff;
                    state      <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (cnt == '0) begin
                        state <= ST_ADD;
                    end else begin
                        mant_small <= {1'b0, mant_small[MW-1:2],
                                       mant_small[1] | mant_small[0]};
                        cnt        <= cnt - ONE;
                    end
                end
                ST_ADD: begin
                    mant_big <= sum;
                    if (sum == '0) begin
                        sign_big <= 1'b0;   // exact cancellation gives +0
                        state    <= ST_PACK;
                    end else if (norm_need) begin
                        state <= ST_NORM;
                    end else begin
                        state <= ST_PACK;
                    end
                end
                ST_NORM: begin
                    mant_big <= mant_step;
                    exp_reg  <= exp_step;
                    if (!need_step) state <= ST_PACK;
                end
                ST_PACK: begin
`ifdef FLT_ROUND_EN
                    if (!pack_phase) begin
                        pack_phase <= 1'b1;
                        if (rnd[MAN_W+1]) begin
                            mant_big <= {1'b0, rnd[MAN_W+1:1], 3'b000};
                            exp_reg  <= exp_reg + ONE;
                        end else begin
                            mant_big <= {rnd, 3'b000};
                        end
                    end else begin
                        pack_phase <= 1'b0;
                        result     <= packed_val;
                        ack        <= 1'b1;
                        state      <= ST_DONE;
                    end
`else
                    result <= packed_val;
                    ack    <= 1'b1;
                    state  <= ST_DONE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flt_addsub.sv
module tb_flt_addsub;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        sub = 1'b0;
    logic [15:0] result;
    logic        ack;

    int checks = 0;
    int failures = 0;

`ifdef FLT_ROUND_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    flt_addsub #(.EXP_W(5), .MAN_W(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .sub    (sub),
        .result (result),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Called at #1 after a rising edge. pulse_at>0 fires a second start
    // (4500-4500) that many cycles after the first start edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] want, input int lat,
                          input int pulse_at);
        int cyc;
        logic done;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ackclr"}, 32'(ack), 32'd0);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            if (pulse_at != 0 && cyc == pulse_at) begin
                op_a = 16'h4500; op_b = 16'h4500; sub = 1'b1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (ack) done = 1'b1;
        end
        chk({tag, "_ack"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_res"}, 32'(result), 32'(want));
        $display("op %s a=%04h b=%04h sub=%0d result=%04h cycles=%0d", tag, a, b, s, result, cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("carry",    16'h1A04, 16'h1A04, 1'b0, 16'h1E04, 5 + RL, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_hold", 32'(ack), 32'd1);
        chk("res_hold", 32'(result), 32'h1E04);

        run_op("sub_norm", 16'h3C00, 16'h3800, 1'b1, 16'h3800, 6 + RL, 0);
        run_op("zero",     16'h4500, 16'h4500, 1'b1, 16'h0000, 4 + RL, 0);
        run_op("overflow", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5 + RL, 0);
        run_op("cap_ign",  16'h3C00, 16'h0001, 1'b0, 16'h3C00, 17 + RL, 4);
        run_op("subn_add", 16'h0001, 16'h0001, 1'b0, 16'h0002, 4 + RL, 0);
        run_op("subn_sub", 16'h0400, 16'h03FF, 1'b1, 16'h0001, 4 + RL, 0);
        run_op("neg_diff", 16'h3800, 16'h3C00, 1'b1, 16'hB800, 6 + RL, 0);
        run_op("neg_add",  16'hC000, 16'hC000, 1'b0, 16'hC400, 5 + RL, 0);
`ifdef FLT_ROUND_EN
        run_op("round",    16'h3C03, 16'h3C00, 1'b0, 16'h4002, 6, 0);
`else
        run_op("trunc",    16'h3C03, 16'h3C00, 1'b0, 16'h4001, 5, 0);
`endif

        // Reset three cycles into an operation aborts it.
        op_a = 16'h3C00; op_b = 16'h3800; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_res", 32'(result), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_noack", 32'(ack), 32'd0);
        run_op("fresh",    16'h3C00, 16'h3800, 1'b0, 16'h3E00, 5 + RL, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
